glitch_filter: RTL

//  Downstream consumer of the 4-input combinational function output x. Samples x,

---
 rtl/glitch_pkg.sv | 18 +
 rtl/glitch_filter_sync_2ff.sv | 28 ++
 rtl/glitch_filter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/glitch_pkg.sv
// Shared types and defaults for the glitch filter.
// Used by glitch_filter and its synchroniser.
package glitch_pkg;

    typedef enum logic {
        STABLE,
        CANDIDATE
    } gf_state_t;

    localparam int FILT_CYCLES_DEF = 4;
    localparam int CNT_W_DEF       = 8;

    // Run counter must hold FILT_CYCLES-1 without wrapping.
    function automatic int run_width(input int filt_cycles);
        return $clog2(filt_cycles + 1);
    endfunction

endpackage

// File: rtl/glitch_filter_sync_2ff.sv
// Two-flop synchroniser with a parameterised reset value.
// The only place the raw input is sampled.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/glitch_filter.sv
// Glitch filter: sync, N-sample level acceptance, edge strobes.
// Glitch statistics are built only with GLITCH_FILTER_STATS_EN.
module glitch_filter
    import glitch_pkg::*;
#(
    parameter int   FILT_CYCLES = FILT_CYCLES_DEF,
    parameter int   CNT_W       = CNT_W_DEF,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_in,
    output logic             x_filt,
    output logic             rise,
    output logic             fall,
    output logic             glitch,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int RUN_W = run_width(FILT_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_CYCLES - 1);

    logic xs;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (x_in),
        .q_o   (xs)
    );

    gf_state_t        state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             filt_q, filt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             reject;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        filt_d  = filt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        reject  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (xs != filt_q) begin
                    state_d = CANDIDATE;
                    run_d   = RUN_ONE;
                end
            end
            CANDIDATE: begin
                if (xs == filt_q) begin
                    reject  = 1'b1;
                    state_d = STABLE;
                    run_d   = '0;
                end else if (run_q == RUN_LAST) begin
                    filt_d  = xs;
                    rise_d  = xs;
                    fall_d  = ~xs;
                    state_d = STABLE;
                    run_d   = '0;
                end else begin
                    run_d = run_q + RUN_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            run_q   <= '0;
            filt_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign x_filt = filt_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

`ifdef GLITCH_FILTER_STATS_EN
    logic             glitch_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate rather than wrap so a hazard storm stays visible.
    always_comb begin
        cnt_d = cnt_q;
        if (reject && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            glitch_q <= reject;
            cnt_q    <= cnt_d;
        end
    end

    assign glitch     = glitch_q;
    assign glitch_cnt = cnt_q;
`else
    logic stats_unused;

    assign stats_unused = reject;
    assign glitch       = 1'b0;
    assign glitch_cnt   = '0;
`endif

    a_strobe_excl : assert property (
        @(posedge clk) disable iff (!rst_n)
        $onehot0({rise, fall, glitch})
    );

    a_run_bound : assert property (
        @(posedge clk) disable iff (!rst_n)
        run_q <= RUN_LAST
    );

endmodule
